// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array front end.
// Holds the default operand/accumulator widths, the default row count,
// the signed operand type and the row skewer FSM state encoding.
package sa_pkg;
  localparam int SA_WIDTH = 8;   // operand width per lane (matches mac WIDTH)
  localparam int SA_ACC_W = 32;  // mac accumulator width
  localparam int SA_N     = 4;   // lanes / array rows

  typedef logic signed [SA_WIDTH-1:0] sa_operand_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } sa_skew_state_t;
endpackage

// File: rtl/sa_delay_line.sv
// sa_delay_line: DEPTH-stage shift register of {valid, data}.
// A cycle with in_vld=0 shifts in a bubble (valid 0, data 0), so data is
// zero wherever valid is zero. hold freezes every stage; rst_n clears them.
// Ports:
//   clk, rst_n      clock, synchronous active-low clear
//   hold            freeze all stages this cycle
//   in_vld/in_data  stage-1 input
//   out_vld/out_data  last-stage contents
//   occupied        any stage holds a valid entry
module sa_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  output logic             occupied
);

  logic [DEPTH:1]            vld_pipe;
  logic [DEPTH:1][WIDTH-1:0] dat_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else if (!hold) begin
      vld_pipe[1] <= in_vld;
      dat_pipe[1] <= in_vld ? in_data : '0;
      for (int k = 2; k <= DEPTH; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign out_vld  = vld_pipe[DEPTH];
  assign out_data = dat_pipe[DEPTH];
  assign occupied = |vld_pipe;

endmodule

// File: rtl/sa_row_skewer.sv
// sa_row_skewer: input staging for the systolic array.
// Accepts one N-lane operand vector per transfer and delays lane i by i+1
// non-stalled cycles, forming the diagonal wavefront the mac rows expect.
// After a frame's last vector the block refuses input until the skew has
// drained, so frames never overlap inside the array.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    handshake; transfer = in_valid & in_ready
//   in_data              N lanes, lane i = in_data[i*WIDTH +: WIDTH]
//   in_last              vector ends the frame
//   stall                global freeze from array control
//   out_data/out_en      skewed operand and enable per mac row
//   out_last             marks lane N-1 output of the frame's last vector
//   busy                 frame in progress or data in flight
module sa_row_skewer
  import sa_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH,
  parameter int N     = SA_N
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic               in_last,
  input  logic               stall,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_en,
  output logic               out_last,
  output logic               busy
);

  localparam int CNT_W = $clog2(N + 1);

  sa_skew_state_t         state, state_nxt;
  logic [CNT_W-1:0]       drain_cnt;
  logic                   xfer;
  logic [N-1:0]           lane_vld;
  logic [N-1:0]           lane_occ;
  logic [N-1:0][WIDTH-1:0] lane_dat;
  logic                   last_q;

  assign xfer = in_valid & in_ready;

  // Lane i is i+1 stages deep; the tail lane also carries in_last so the
  // frame marker lines up with the final operand of the wavefront.
  for (genvar i = 0; i < N; i++) begin : g_lane
    if (i == N-1) begin : g_tail
      logic [WIDTH:0] tail_q;
      sa_delay_line #(.WIDTH(WIDTH+1), .DEPTH(i+1)) u_dl (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (stall),
        .in_vld   (xfer),
        .in_data  ({in_last, in_data[i*WIDTH +: WIDTH]}),
        .out_vld  (lane_vld[i]),
        .out_data (tail_q),
        .occupied (lane_occ[i])
      );
      assign lane_dat[i] = tail_q[WIDTH-1:0];
      assign last_q      = tail_q[WIDTH];
    end else begin : g_body
      sa_delay_line #(.WIDTH(WIDTH), .DEPTH(i+1)) u_dl (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (stall),
        .in_vld   (xfer),
        .in_data  (in_data[i*WIDTH +: WIDTH]),
        .out_vld  (lane_vld[i]),
        .out_data (lane_dat[i]),
        .occupied (lane_occ[i])
      );
    end
  end

  // Enables are masked during stall so the macs never re-accumulate held data;
  // the data itself stays on the bus.
  assign out_data = lane_dat;
  assign out_en   = lane_vld & {N{~stall}};
  assign out_last = last_q & lane_vld[N-1] & ~stall;

  // Drain counter: loaded on the last transfer, hits zero together with out_last.
  always_ff @(posedge clk) begin
    if (!rst_n)
      drain_cnt <= '0;
    else if (xfer && in_last)
      drain_cnt <= CNT_W'(N);
    else if (!stall && drain_cnt != '0)
      drain_cnt <= drain_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = in_last ? DRAIN : STREAM;
      STREAM:  if (xfer && in_last) state_nxt = DRAIN;
      DRAIN:   if (out_last) state_nxt = IDLE;  // out_last already excludes stall
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = !stall && (state != DRAIN);
    busy     = (state != IDLE) || (drain_cnt != '0) || (|lane_occ);
  end

endmodule
